// File: rtl/lab4_adder_bist_if.sv
// Bus between the BIST engine (master) and the adder-under-test / lab board side (slave).
// Carries the start/status handshake as well as the adder operand and result signals.
interface lab4_adder_bist_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 c0;
  logic [WIDTH-1:0]     s;
  logic                 c4;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH+1:0]   errCnt;
  logic [2*WIDTH:0]     failVec;

  modport master (
    input  start, s, c4,
    output a, b, c0, busy, done, pass, errCnt, failVec
  );

  modport slave (
    output start, s, c4,
    input  a, b, c0, busy, done, pass, errCnt, failVec
  );
endinterface

// File: rtl/lab4_adder_bist.sv
// BIST engine for the lab ripple adder: sweeps every {A,B,C0}, checks {C4,S} LAT edges later.
// Optional macro LAB4_FAIL_CAPTURE_EN builds a register holding the first failing vector.
module lab4_adder_bist #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lab4_adder_bist_if.master   adder_io
);

  localparam int IW = 2*WIDTH + 1;
  localparam int CW = 2*WIDTH + 2;
  localparam logic [IW-1:0] PENULT = {{(IW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     pipeVec_q [LAT];
  logic [LAT-1:0]    pipeVld_q;
  logic              issue;
  logic [CW-1:0]     errCnt_q, errCnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [IW-1:0]     tapVec;
  logic              tapVld;
  logic [WIDTH:0]    refSum;
  logic              mismatch;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (adder_io.start) state_d = RUN;
      RUN:        if (idx_q == PENULT) state_d = DRAIN;
      DRAIN:      if (pipeVld_q == '0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // The tail of the delay line holds the vector whose result is on S/C4 right now.
  assign tapVec   = pipeVec_q[LAT-1];
  assign tapVld   = pipeVld_q[LAT-1];
  assign refSum   = (WIDTH+1)'(tapVec[IW-1:WIDTH+1]) + (WIDTH+1)'(tapVec[WIDTH:1])
                  + (WIDTH+1)'(tapVec[0]);
  assign mismatch = tapVld && ({adder_io.c4, adder_io.s} != refSum);

  always_comb begin
    idx_d    = idx_q;
    issue    = 1'b0;
    errCnt_d = errCnt_q;
    if (mismatch && (errCnt_q != '1)) errCnt_d = errCnt_q + 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (adder_io.start) begin
          idx_d    = '0;
          issue    = 1'b1;
          errCnt_d = '0;
        end
      end
      RUN: begin
        idx_d = idx_q + 1'b1;
        issue = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (errCnt_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      pipeVld_q <= '0;
      for (int k = 0; k < LAT; k++) pipeVec_q[k] <= '0;
      errCnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pipeVec_q[0] <= idx_d;
      pipeVld_q[0] <= issue;
      for (int k = LAT-1; k > 0; k--) begin
        pipeVec_q[k] <= pipeVec_q[k-1];
        pipeVld_q[k] <= pipeVld_q[k-1];
      end
      errCnt_q <= errCnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

`ifdef LAB4_FAIL_CAPTURE_EN
  logic [IW-1:0] failVec_q, failVec_d;

  // Only the first mismatch of a sweep is kept; a zero count means no earlier mismatch this sweep.
  always_comb begin
    failVec_d = failVec_q;
    if (mismatch && (errCnt_q == '0)) failVec_d = tapVec;
    if (((state_q == IDLE) || (state_q == DONE)) && adder_io.start) failVec_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) failVec_q <= '0;
    else       failVec_q <= failVec_d;
  end

  assign adder_io.failVec = failVec_q;
`else
  assign adder_io.failVec = '0;
`endif

  assign adder_io.a      = idx_q[IW-1:WIDTH+1];
  assign adder_io.b      = idx_q[WIDTH:1];
  assign adder_io.c0     = idx_q[0];
  assign adder_io.busy   = busy_q;
  assign adder_io.done   = done_q;
  assign adder_io.pass   = pass_q;
  assign adder_io.errCnt = errCnt_q;

endmodule

// File: tb/tb_lab4_adder_bist.sv
// Directed bench for lab4_adder_bist: one LAT=1 engine against selectable adder models and
// one LAT=2 engine against a registered adder, both started by a shared START.
module tb_lab4_adder_bist;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lab4_adder_bist_if #(.WIDTH(4)) bus1 ();
  lab4_adder_bist_if #(.WIDTH(4)) bus2 ();

  lab4_adder_bist #(.WIDTH(4), .LAT(1)) dut1 (.clk_i(clk), .rst_i(rst), .adder_io(bus1));
  lab4_adder_bist #(.WIDTH(4), .LAT(2)) dut2 (.clk_i(clk), .rst_i(rst), .adder_io(bus2));

`ifdef LAB4_FAIL_CAPTURE_EN
  localparam bit CAPTURE = 1'b1;
`else
  localparam bit CAPTURE = 1'b0;
`endif

  // Adder models: mode 0 good, 1 C4 stuck-at-0, 2 S[0] stuck-at-0, 3 registered outputs.
  logic [4:0] goodSum1, sumReg1, sumReg2, res1;

  always_comb goodSum1 = {1'b0, bus1.a} + {1'b0, bus1.b} + {4'b0, bus1.c0};

  always @(posedge clk) begin
    sumReg1 <= goodSum1;
    sumReg2 <= {1'b0, bus2.a} + {1'b0, bus2.b} + {4'b0, bus2.c0};
  end

  always_comb begin
    case (mode)
      0:       res1 = goodSum1;
      1:       res1 = {1'b0, goodSum1[3:0]};
      2:       res1 = {goodSum1[4:1], 1'b0};
      default: res1 = sumReg1;
    endcase
  end

  assign {bus1.c4, bus1.s} = res1;
  assign {bus2.c4, bus2.s} = sumReg2;
  assign bus1.start = start;
  assign bus2.start = start;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sweep from a START pulse; expErr1<0 means "any nonzero", expVec1<0 skips FAIL_VEC.
  task automatic applyStimulus(input string tag, input int m, input int repulseAt,
                               input int abortAt, input int expErr1, input int expVec1,
                               input int expPass1);
    int edges;
    int done1At;
    int done2At;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy0"}, 32'(bus1.busy), 1);
    checkOutput({tag, "_vec0"}, 32'({bus1.a, bus1.b, bus1.c0}), 0);
    checkOutput({tag, "_err0"}, 32'(bus1.errCnt), 0);
    checkOutput({tag, "_done0"}, 32'(bus1.done), 0);
    edges   = 0;
    done1At = -1;
    done2At = -1;
    while ((done1At < 0 || done2At < 0) && edges < 2000) begin
      start = (edges == repulseAt - 1);
      @(posedge clk);
      edges++;
      #1;
      if (edges == 37) begin
        checkOutput({tag, "_walk37"}, 32'({bus1.a, bus1.b, bus1.c0}), 37);
        checkOutput({tag, "_busy37"}, 32'(bus1.busy), 1);
      end
      if (edges == abortAt) begin
        start = 1'b0;
        rst   = 1'b1;
        #1;
        checkOutput({tag, "_abort_busy"}, 32'(bus1.busy), 0);
        checkOutput({tag, "_abort_vec"}, 32'({bus1.a, bus1.b, bus1.c0}), 0);
        checkOutput({tag, "_abort_err"}, 32'(bus1.errCnt), 0);
        checkOutput({tag, "_abort_done"}, 32'(bus1.done), 0);
        checkOutput({tag, "_abort_busy2"}, 32'(bus2.busy), 0);
        #1;
        rst = 1'b0;
        return;
      end
      if (bus1.done && done1At < 0) done1At = edges;
      if (bus2.done && done2At < 0) done2At = edges;
    end
    start = 1'b0;
    checkOutput({tag, "_done1_edge"}, 32'(done1At), 513);
    checkOutput({tag, "_done2_edge"}, 32'(done2At), 514);
    checkOutput({tag, "_busy_end"}, 32'(bus1.busy), 0);
    checkOutput({tag, "_pass1"}, 32'(bus1.pass), 32'(expPass1));
    if (expErr1 < 0) checkOutput({tag, "_err1_nonzero"}, 32'(bus1.errCnt != 0), 1);
    else             checkOutput({tag, "_err1"}, 32'(bus1.errCnt), 32'(expErr1));
    if (expVec1 >= 0)
      checkOutput({tag, "_failvec1"}, 32'(bus1.failVec), CAPTURE ? 32'(expVec1) : 0);
    checkOutput({tag, "_pass2"}, 32'(bus2.pass), 1);
    checkOutput({tag, "_err2"}, 32'(bus2.errCnt), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    #12;
    checkOutput("rst_busy", 32'(bus1.busy), 0);
    checkOutput("rst_done", 32'(bus1.done), 0);
    checkOutput("rst_pass", 32'(bus1.pass), 0);
    checkOutput("rst_err", 32'(bus1.errCnt), 0);
    checkOutput("rst_failvec", 32'(bus1.failVec), 0);
    checkOutput("rst_vec", 32'({bus1.a, bus1.b, bus1.c0}), 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("good_repulse", 0, 50, -1, 0, 0, 1);
    applyStimulus("c4_stuck", 1, -1, -1, 256, 9'h01F, 0);
    applyStimulus("s0_stuck", 2, -1, -1, 256, 9'h001, 0);
    applyStimulus("good_after_fail", 0, -1, -1, 0, 0, 1);
    applyStimulus("reg_lat1", 3, -1, -1, -1, -1, 0);
    applyStimulus("abort", 0, -1, 100, 0, 0, 1);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(bus1.busy), 0);
    checkOutput("idle_done", 32'(bus1.done), 0);
    applyStimulus("after_abort", 0, -1, -1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
